// File: rtl/led_strip_if.sv
// ============================================================================
//  Module      : led_strip_if
//  Description : Zone-mean frame input and serial LED status bundle for
//                led_strip_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_strip_if;
  logic [7:0][3:0] MeanR;
  logic [7:0][3:0] MeanG;
  logic [7:0][3:0] MeanB;
  logic            start_i;
  logic            led_dout;
  logic            busy;
  logic            frame_done;

  modport master (
    output MeanR, MeanG, MeanB, start_i,
    input  led_dout, busy, frame_done
  );

  modport slave (
    input  MeanR, MeanG, MeanB, start_i,
    output led_dout, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/led_strip_tx.sv
// ============================================================================
//  Module      : led_strip_tx
//  Description : WS2812-style serialiser for 8 zones x RGB 4-bit means, with a
//                one-deep pending frame buffer. Define LED_GAMMA_EN for n*n
//                intensity expansion instead of nibble replication.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_strip_tx #(
  parameter int unsigned T0H  = 20,
  parameter int unsigned T1H  = 40,
  parameter int unsigned TBIT = 63,
  parameter int unsigned TRST = 15000
) (
  input  logic        clk,
  input  logic        rst_n,
  led_strip_if.slave  bus
);

  localparam logic [15:0] C_T0H_LAST  = 16'(T0H - 1);
  localparam logic [15:0] C_T1H_LAST  = 16'(T1H - 1);
  localparam logic [15:0] C_TBIT_LAST = 16'(TBIT - 1);
  localparam logic [15:0] C_TRST_LAST = 16'(TRST - 1);
  localparam logic [7:0]  C_BIT_LAST  = 8'd191;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic [7:0]      r_idx, w_idx_nxt;
  logic            r_pending;
  logic            r_dout;
  logic [7:0][3:0] r_act_r, r_act_g, r_act_b;
  logic [7:0][3:0] r_pend_r, r_pend_g, r_pend_b;

  logic            w_load_new;
  logic            w_load_pend;
  logic            w_frame_done;
  logic            w_store_pend;
  logic [2:0]      w_zone;
  logic [4:0]      w_pos;
  logic [3:0]      w_nib;
  logic [7:0]      w_byte;
  logic            w_bit;
  logic [15:0]     w_high_last;

  function automatic logic [7:0] f_expand(input logic [3:0] n);
`ifdef LED_GAMMA_EN
    return {4'b0000, n} * {4'b0000, n};
`else
    return {n, n};
`endif
  endfunction

  // Split the 0..191 bit index into zone (24 bits each) and position in zone.
  always_comb begin
    w_zone = 3'd0;
    for (int z = 1; z < 8; z++) begin
      if (r_idx >= 8'(24 * z)) w_zone = 3'(z);
    end
    w_pos = 5'(r_idx - ({5'b00000, w_zone} * 8'd24));
    case (w_pos[4:3])
      2'd0:    w_nib = r_act_g[w_zone];
      2'd1:    w_nib = r_act_r[w_zone];
      default: w_nib = r_act_b[w_zone];
    endcase
    w_byte      = f_expand(w_nib);
    w_bit       = w_byte[3'd7 - w_pos[2:0]];
    w_high_last = w_bit ? C_T1H_LAST : C_T0H_LAST;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_idx_nxt    = r_idx;
    w_load_new   = 1'b0;
    w_load_pend  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (bus.start_i) begin
          w_state_nxt = S_HIGH;
          w_idx_nxt   = 8'd0;
          w_load_new  = 1'b1;
        end
      end
      S_HIGH: begin
        if (r_cnt == w_high_last) w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (r_cnt == C_TBIT_LAST) begin
          w_cnt_nxt = 16'd0;
          if (r_idx == C_BIT_LAST) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_state_nxt = S_HIGH;
            w_idx_nxt   = r_idx + 8'd1;
          end
        end
      end
      S_LATCH: begin
        if (r_cnt == C_TRST_LAST) begin
          w_frame_done = 1'b1;
          w_cnt_nxt    = 16'd0;
          w_idx_nxt    = 8'd0;
          // A start in this very cycle outranks any older pending frame.
          if (bus.start_i) begin
            w_state_nxt = S_HIGH;
            w_load_new  = 1'b1;
          end else if (r_pending) begin
            w_state_nxt = S_HIGH;
            w_load_pend = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_store_pend = bus.start_i && (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_idx     <= 8'd0;
      r_dout    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dout  <= (w_state_nxt == S_HIGH);
      if (w_load_new || w_load_pend) begin
        r_pending <= 1'b0;
      end else if (w_store_pend) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_new) begin
      r_act_r <= bus.MeanR;
      r_act_g <= bus.MeanG;
      r_act_b <= bus.MeanB;
    end else if (w_load_pend) begin
      r_act_r <= r_pend_r;
      r_act_g <= r_pend_g;
      r_act_b <= r_pend_b;
    end
    if (w_store_pend) begin
      r_pend_r <= bus.MeanR;
      r_pend_g <= bus.MeanG;
      r_pend_b <= bus.MeanB;
    end
  end

  assign bus.led_dout   = r_dout;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_led_strip_tx.sv
// Directed bench for led_strip_tx: one default-timing instance and one with
// minimal timing (T0H=1, T1H=2, TBIT=3, TRST=1); serial output is decoded by pulse width.
`default_nettype none

module tb_led_strip_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  led_strip_if if_d ();
  led_strip_if if_s ();

  led_strip_tx u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d)
  );

  led_strip_tx #(
    .T0H  (1),
    .T1H  (2),
    .TBIT (3),
    .TRST (1)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  function automatic logic [7:0] exp_byte(input logic [3:0] n);
`ifdef LED_GAMMA_EN
    return 8'(n * n);
`else
    return 8'(n * 17);
`endif
  endfunction

  // Expected 192-bit stream, first transmitted bit at [191].
  function automatic logic [191:0] exp_frame(input logic [31:0] r, input logic [31:0] g,
                                             input logic [31:0] b);
    logic [191:0] f;
    f = '0;
    for (int z = 0; z < 8; z++) begin
      f = {f[183:0], exp_byte(g[z*4 +: 4])};
      f = {f[183:0], exp_byte(r[z*4 +: 4])};
      f = {f[183:0], exp_byte(b[z*4 +: 4])};
    end
    return f;
  endfunction

  // Called at a falling edge; holds start_i for one full clock period.
  task automatic pulse_start(input bit use_def, input logic [31:0] r, input logic [31:0] g,
                             input logic [31:0] b);
    if (use_def) begin
      if_d.MeanR = r; if_d.MeanG = g; if_d.MeanB = b; if_d.start_i = 1'b1;
    end else begin
      if_s.MeanR = r; if_s.MeanG = g; if_s.MeanB = b; if_s.start_i = 1'b1;
    end
    @(negedge clk);
    if_d.start_i = 1'b0;
    if_s.start_i = 1'b0;
  endtask

  // Starts at the falling edge of cycle N+1 (t=1) and returns at the falling
  // edge of the cycle where frame_done is seen (done_t = -1 on timeout).
  task automatic capture(input bit use_def, input int tbit, input int t0h, input int t1h,
                         input int budget, output logic [191:0] bits, output int nbits,
                         output int nbad, output int nbusy_lo, output int done_t);
    int   t;
    int   run;
    logic prev;
    logic d;
    logic fd;
    t = 1; run = 0; prev = 1'b0;
    bits = '0; nbits = 0; nbad = 0; nbusy_lo = 0; done_t = -1;
    forever begin
      d  = use_def ? if_d.led_dout : if_s.led_dout;
      fd = use_def ? if_d.frame_done : if_s.frame_done;
      if (!(use_def ? if_d.busy : if_s.busy)) nbusy_lo++;
      if (d && !prev && (t != 1 + nbits * tbit)) nbad++;
      if (d) begin
        run++;
      end else if (prev) begin
        if (run == t1h) begin
          if (nbits < 192) bits[191 - nbits] = 1'b1;
        end else if (run != t0h) begin
          nbad++;
        end
        nbits++;
        run = 0;
      end
      prev = d;
      if (fd) begin
        done_t = t;
        break;
      end
      if (t >= budget) break;
      t++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (if_s.led_dout !== 1'b0) begin n_fail++; $display("FAIL rst_dout: got %b want 0", if_s.led_dout); end
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", if_s.busy); end
    n_checks++; if (if_s.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", if_s.frame_done); end
    n_checks++; if (if_d.led_dout !== 1'b0) begin n_fail++; $display("FAIL rst_dout_def: got %b want 0", if_d.led_dout); end
    n_checks++; if (if_d.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_def: got %b want 0", if_d.busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [191:0] bits;
    int nbits, nbad, nbl, done_t;
    pulse_start(1'b0, 32'h7654_3210, 32'hFEDC_BA98, 32'h5A5A_0F0F);
    repeat (19) @(negedge clk);
    pulse_start(1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    repeat (130) @(negedge clk);
    // Cycle 151: high phase of bit 50.
    n_checks++; if (if_s.led_dout !== 1'b1) begin n_fail++; $display("FAIL mid_bit50_high: got %b want 1", if_s.led_dout); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (if_s.led_dout !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dout: got %b want 0", if_s.led_dout); end
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", if_s.busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL mid_pending_dropped: busy %b want 0", if_s.busy); end
    pulse_start(1'b0, 32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4);
    capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
    n_checks++; if (bits !== exp_frame(32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4)) begin n_fail++; $display("FAIL post_rst_bits: got %h want %h", bits, exp_frame(32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4)); end
    n_checks++; if (nbits !== 192) begin n_fail++; $display("FAIL post_rst_nbits: got %0d want 192", nbits); end
    n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL post_rst_timing: got %0d bad pulses want 0", nbad); end
    n_checks++; if (done_t !== 577) begin n_fail++; $display("FAIL small_frame_len: got %0d want 577", done_t); end
    @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy_end: got %b want 0", if_s.busy); end
  endtask

  task automatic test_zero_default();
    logic [191:0] bits;
    int nbits, nbad, nbl, done_t;
    pulse_start(1'b1, 32'h0, 32'h0, 32'h0);
    capture(1'b1, 63, 20, 40, 30000, bits, nbits, nbad, nbl, done_t);
    n_checks++; if (bits !== 192'd0) begin n_fail++; $display("FAIL zero_bits: got %h want 0", bits); end
    n_checks++; if (nbits !== 192) begin n_fail++; $display("FAIL zero_nbits: got %0d want 192", nbits); end
    n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL zero_timing: got %0d bad pulses want 0", nbad); end
    n_checks++; if (nbl !== 0) begin n_fail++; $display("FAIL zero_busy_during: low %0d cycles want 0", nbl); end
    n_checks++; if (done_t !== 27096) begin n_fail++; $display("FAIL zero_done_time: got %0d want 27096", done_t); end
    @(negedge clk);
    n_checks++; if (if_d.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_end: got %b want 0", if_d.busy); end
  endtask

  task automatic test_zone_data();
    logic [191:0] bits;
    logic [23:0]  head;
    logic [7:0]   tail;
    int nbits, nbad, nbl, done_t;
`ifdef LED_GAMMA_EN
    head = 24'hE1_01_40; tail = 8'h09;
`else
    head = 24'hFF_11_88; tail = 8'h33;
`endif
    pulse_start(1'b0, 32'h0000_0001, 32'h0000_000F, 32'h3000_0008);
    capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
    n_checks++; if (bits[191:168] !== head) begin n_fail++; $display("FAIL zone0_bytes: got %h want %h", bits[191:168], head); end
    n_checks++; if (bits[7:0] !== tail) begin n_fail++; $display("FAIL zone7_blue: got %h want %h", bits[7:0], tail); end
    n_checks++; if (bits[167:8] !== 160'd0) begin n_fail++; $display("FAIL zone_middle: got %h want 0", bits[167:8]); end
    n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL zone_timing: got %0d bad pulses want 0", nbad); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [191:0] bits;
    int nbits, nbad, nbl, done_t;
    pulse_start(1'b0, 32'hA1A1_A1A1, 32'h5C5C_5C5C, 32'h0123_4567);
    fork
      capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
      begin
        repeat (20) @(negedge clk);
        pulse_start(1'b0, 32'hBBBB_BBBB, 32'hB0B0_B0B0, 32'h0B0B_0B0B);
        repeat (80) @(negedge clk);
        pulse_start(1'b0, 32'hCCCC_CCCC, 32'hC0C0_C0C0, 32'h0C0C_0C0C);
        repeat (200) @(negedge clk);
        pulse_start(1'b0, 32'hD4E5_F607, 32'h1829_3A4B, 32'h5C6D_7E8F);
      end
    join
    n_checks++; if (bits !== exp_frame(32'hA1A1_A1A1, 32'h5C5C_5C5C, 32'h0123_4567)) begin n_fail++; $display("FAIL b2b_frameA: got %h", bits); end
    n_checks++; if (done_t !== 577) begin n_fail++; $display("FAIL b2b_doneA: got %0d want 577", done_t); end
    @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_gap: got %b want 1", if_s.busy); end
    n_checks++; if (if_s.led_dout !== 1'b1) begin n_fail++; $display("FAIL b2b_next_rise: got %b want 1", if_s.led_dout); end
    capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
    n_checks++; if (bits !== exp_frame(32'hD4E5_F607, 32'h1829_3A4B, 32'h5C6D_7E8F)) begin n_fail++; $display("FAIL b2b_frameD: got %h want %h", bits, exp_frame(32'hD4E5_F607, 32'h1829_3A4B, 32'h5C6D_7E8F)); end
    n_checks++; if (nbad !== 0 || nbits !== 192) begin n_fail++; $display("FAIL b2b_timingD: got %0d bad, %0d bits want 0, 192", nbad, nbits); end
    n_checks++; if (done_t !== 577) begin n_fail++; $display("FAIL b2b_doneD: got %0d want 577", done_t); end
    @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_only_one_extra: busy %b want 0", if_s.busy); end
  endtask

  task automatic test_latch_coincident();
    logic [191:0] bits;
    int nbits, nbad, nbl, done_t;
    pulse_start(1'b0, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_0000);
    fork
      capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
      begin
        repeat (50) @(negedge clk);
        pulse_start(1'b0, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888);
      end
    join
    n_checks++; if (done_t !== 577) begin n_fail++; $display("FAIL coin_doneE: got %0d want 577", done_t); end
    n_checks++; if (if_s.frame_done !== 1'b1) begin n_fail++; $display("FAIL coin_done_pulse: got %b want 1", if_s.frame_done); end
    pulse_start(1'b0, 32'h9ABC_DEF0, 32'h0FED_CBA9, 32'h4321_8765);
    n_checks++; if (if_s.led_dout !== 1'b1) begin n_fail++; $display("FAIL coin_next_rise: got %b want 1", if_s.led_dout); end
    n_checks++; if (if_s.busy !== 1'b1) begin n_fail++; $display("FAIL coin_busy: got %b want 1", if_s.busy); end
    capture(1'b0, 3, 1, 2, 2000, bits, nbits, nbad, nbl, done_t);
    n_checks++; if (bits !== exp_frame(32'h9ABC_DEF0, 32'h0FED_CBA9, 32'h4321_8765)) begin n_fail++; $display("FAIL coin_frameF: got %h want %h", bits, exp_frame(32'h9ABC_DEF0, 32'h0FED_CBA9, 32'h4321_8765)); end
    n_checks++; if (done_t !== 577) begin n_fail++; $display("FAIL coin_doneF: got %0d want 577", done_t); end
    @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL coin_stale_pending: busy %b want 0", if_s.busy); end
  endtask

  initial begin
    if_d.MeanR = '0; if_d.MeanG = '0; if_d.MeanB = '0; if_d.start_i = 1'b0;
    if_s.MeanR = '0; if_s.MeanG = '0; if_s.MeanB = '0; if_s.start_i = 1'b0;
    test_reset();
    test_reset_mid_frame();
    test_zero_default();
    test_zone_data();
    test_back_to_back();
    test_latch_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
